// File: rtl/step_interval_timer.sv
// Multi-channel interval timer: each channel counts cycles whose step code equals
// ACTIVE_STEP and emits a registered one-cycle done pulse when its period elapses.
module step_interval_timer #(
    parameter int STEP_W      = 4,
    parameter int ACTIVE_STEP = 2,
    parameter int CNT_W       = 8,
    parameter int NUM_CH      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STEP_W-1:0]       step_i,
    input  logic [NUM_CH-1:0]       start_i,
    input  logic [NUM_CH-1:0]       stop_i,
    input  logic [NUM_CH-1:0]       periodic_i,
    input  logic [NUM_CH*CNT_W-1:0] period_i,
    output logic [NUM_CH-1:0]       busy_o,
    output logic [NUM_CH-1:0]       done_o,
    output logic [NUM_CH*CNT_W-1:0] count_o
);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t             state_q  [NUM_CH];
    state_t             state_d  [NUM_CH];
    logic [CNT_W-1:0]   count_q  [NUM_CH];
    logic [CNT_W-1:0]   count_d  [NUM_CH];
    logic [CNT_W-1:0]   period_q [NUM_CH];
    logic [CNT_W-1:0]   period_d [NUM_CH];
    logic [NUM_CH-1:0]  mode_q;
    logic [NUM_CH-1:0]  mode_d;
    logic [NUM_CH-1:0]  done_q;
    logic [NUM_CH-1:0]  done_d;
    logic               tick;

    assign tick = (step_i == STEP_W'(ACTIVE_STEP));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]  <= S_IDLE;
                count_q[c]  <= '0;
                period_q[c] <= '0;
            end
            mode_q <= '0;
            done_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]  <= state_d[c];
                count_q[c]  <= count_d[c];
                period_q[c] <= period_d[c];
            end
            mode_q <= mode_d;
            done_q <= done_d;
        end
    end

    // Expiry compare is CNT_W-bit modular, so period 0 means 2^CNT_W ticks.
    always_comb begin
        logic [CNT_W-1:0] last_cnt;
        last_cnt = '0;
        mode_d   = mode_q;
        done_d   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c]  = state_q[c];
            count_d[c]  = count_q[c];
            period_d[c] = period_q[c];
            last_cnt    = period_q[c] - CNT_W'(1);
            case (state_q[c])
                S_IDLE: begin
                    if (start_i[c] && !stop_i[c]) begin
                        state_d[c]  = S_RUN;
                        count_d[c]  = '0;
                        period_d[c] = period_i[c*CNT_W +: CNT_W];
                        mode_d[c]   = periodic_i[c];
                    end
                end
                S_RUN: begin
                    if (stop_i[c]) begin
                        state_d[c] = S_IDLE;
                        count_d[c] = '0;
                    end else if (start_i[c]) begin
                        count_d[c]  = '0;
                        period_d[c] = period_i[c*CNT_W +: CNT_W];
                        mode_d[c]   = periodic_i[c];
                    end else if (tick) begin
                        if (count_q[c] == last_cnt) begin
                            count_d[c] = '0;
                            done_d[c]  = 1'b1;
                            if (!mode_q[c]) state_d[c] = S_IDLE;
                        end else begin
                            count_d[c] = count_q[c] + CNT_W'(1);
                        end
                    end
                end
                default: state_d[c] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o  = '0;
        count_o = '0;
        done_o  = done_q;
        for (int c = 0; c < NUM_CH; c++) begin
            busy_o[c]                 = (state_q[c] == S_RUN);
            count_o[c*CNT_W +: CNT_W] = count_q[c];
        end
    end

endmodule

// File: doc/step_interval_timer.md
Name: step_interval_timer

Overview:
Parametrised multi-channel interval timer for the VGA controller's step sequencer. Each channel counts clock cycles in which the sequencer's step code equals a configured active code. When a channel reaches its programmed period, it emits a one-cycle done pulse. Each channel runs independently in one-shot or periodic mode, with its own start/stop control and a readable count.

Parameters:
STEP_W, 4, width of the step code input
ACTIVE_STEP, 2, step code value that counts as a tick
CNT_W, 8, width of the per-channel counter and period
NUM_CH, 2, number of independent channels (1..8)

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  reset, asynchronous, active-high
step  in  STEP_W  current sequencer step code, shared by all channels
start  in  NUM_CH  per-channel arm/restart pulse
stop  in  NUM_CH  per-channel disarm pulse
periodic  in  NUM_CH  per-channel mode, sampled at start: 1 = auto-reload, 0 = one-shot
period  in  NUM_CH*CNT_W  per-channel period in ticks; channel i uses bits [i*CNT_W +: CNT_W]
busy  out  NUM_CH  channel armed (in RUN state)
done  out  NUM_CH  registered expiry pulse, exactly one cycle wide
count  out  NUM_CH*CNT_W  per-channel current tick count, same packing as period

Behaviour:
- Reset: clk and rst as decided (rst asynchronous, active-high). While rst is high, every channel is IDLE, count=0, busy=0, done=0, and the latched period and mode are 0.
- Tick: tick = (step == ACTIVE_STEP), evaluated combinationally each cycle and shared by all channels.
- Per-channel FSM, state IDLE:
  - start=1 and stop=0 -> go to RUN, count<=0, latch period[i] and periodic[i].
  - A tick in the start cycle is not counted.
- Per-channel FSM, state RUN:
  - stop=1 -> go to IDLE, count<=0, no done, regardless of tick or start in the same cycle.
  - start=1 (stop=0) -> restart: count<=0, re-latch period and mode, tick in that cycle ignored, no done.
  - tick with count != period_lat-1 -> count<=count+1.
  - tick with count == period_lat-1 -> expiry: count<=0, done<=1 for the next cycle only. Periodic: stay in RUN. One-shot: go to IDLE.
  - no tick -> hold.
- Arithmetic: the comparison uses CNT_W-bit modular arithmetic. period=0 therefore means 2^CNT_W ticks (expiry when count is all ones). period=1 means every tick expires.
- Latency: done is registered. It is high in the cycle immediately after the clock edge that samples the expiring tick; count reads 0 in that same cycle.
- Back-to-back expiry: periodic with period=1 and tick held high gives done high continuously, one pulse per tick, with no gap cycles.
- busy equals (state==RUN) and is a registered output. It falls in the same cycle as the one-shot done pulse.
- Period/mode inputs are ignored except on the start edge; changing them mid-run has no effect.
- Channels share no state: simultaneous events on different channels are fully independent.
- Reset asserted mid-operation aborts any pending done immediately (asynchronous clear). After rst deasserts, no done is emitted until a fresh start.
- stop or start on an IDLE channel with stop=1: no effect.

Test Plan:
- CNT_W=8, ch0 one-shot, period=3, start, step=2 held for 5 cycles -> count 0,1,2,0; done[0] high exactly 1 cycle after the 3rd tick; busy[0] falls with done; the 4th and 5th ticks are ignored.
- ch1 periodic, period=2, step alternating 2,5,2,5,... for 12 cycles -> 3 done pulses spaced 4 cycles apart; busy[1] stays 1; steps other than 2 never advance count.
- ch0 periodic, period=0, step=2 continuous -> first done after 256 ticks, next after 512; count wraps 255->0 exactly at expiry.
- ch0 running at count=1 of period 3: assert start+stop with tick in the same cycle -> IDLE, count=0, no done. Separately, start alone at count=2 with period=5 -> count=0, then 5 more ticks to done.
- Both channels started together, periods 2 and 3, tick continuous -> done[0] at ticks 2,4,6 and done[1] at ticks 3,6; the coincident pulse at tick 6 is independent on each channel.
- Assert rst asynchronously (mid-cycle) with ch0 at count=2 of 3 -> outputs clear immediately; after release, ticks produce no done until a new start.
